// File: rtl/decode_cycle_pkg.sv
// Shared encodings and helpers for the RV32I decode stage.
// Holds the ID/EX payload layout and the immediate and ALU-op decode helpers.
package decode_cycle_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_SLL   = 4'h5,
        ALU_SRL   = 4'h6,
        ALU_SRA   = 4'h7,
        ALU_SLT   = 4'h8,
        ALU_SLTU  = 4'h9,
        ALU_PASSB = 4'hA
    } aluOp_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } resultSrc_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } immSel_t;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       memRead;
        logic       branch;
        logic       jtype;
        logic       aluSrcA;
        logic       aluSrcB;
        resultSrc_t resultSrc;
        aluOp_t     aluControl;
    } ctrl_t;

    typedef struct packed {
        ctrl_t             ctrl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   immExt;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
    } idEx_t;

    // Sign-extended immediate for the selected instruction format.
    function automatic logic [XLEN-1:0] immExtend(input logic [31:0] instr, input immSel_t sel);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // funct7[5] only selects SUB for register-register ops; shifts use it in both forms.
    function automatic aluOp_t aluDecode(input logic [2:0] funct3, input logic funct7b5,
                                         input logic isRType);
        aluOp_t op;
        op = ALU_ADD;
        case (funct3)
            3'd0: op = (isRType && funct7b5) ? ALU_SUB : ALU_ADD;
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd3: op = ALU_SLTU;
            3'd4: op = ALU_XOR;
            3'd5: op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'd6: op = ALU_OR;
            3'd7: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// Reads of the register being written this cycle see the incoming data; x0 reads as zero.
module register_file
    import decode_cycle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] readAddr1,
    input  logic [REG_AW-1:0] readAddr2,
    input  logic              writeEn,
    input  logic [REG_AW-1:0] writeAddr,
    input  logic [XLEN-1:0]   writeData,
    output logic [XLEN-1:0]   readData1_c,
    output logic [XLEN-1:0]   readData2_c
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn && writeAddr != '0) begin
            regs[writeAddr] <= writeData;
        end
    end

    assign readData1_c = (readAddr1 == '0)                     ? '0        :
                         (writeEn && writeAddr == readAddr1)   ? writeData :
                                                                 regs[readAddr1];
    assign readData2_c = (readAddr2 == '0)                     ? '0        :
                         (writeEn && writeAddr == readAddr2)   ? writeData :
                                                                 regs[readAddr2];

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: instruction decode, register read, immediate generation
// and the ID/EX pipeline register feeding execute.
module decode_cycle
    import decode_cycle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              FlushE,
    input  logic              StallE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic [2:0]        Funct3E,
    output logic [3:0]        ALUControlE,
    output logic              ALUSrcAE,
    output logic              ALUSrcBE,
    output logic [1:0]        ResultSrcE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              MemReadE,
    output logic              BranchE,
    output logic              JtypeE
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] rd1_c;
    logic [XLEN-1:0] rd2_c;
    ctrl_t           ctrl;
    immSel_t         immSel;
    idEx_t           idExNext;
    idEx_t           idEx;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];

    register_file uRegFile (
        .clk         (clk),
        .reset       (reset),
        .readAddr1   (InstrD[19:15]),
        .readAddr2   (InstrD[24:20]),
        .writeEn     (RegWriteW),
        .writeAddr   (RdW),
        .writeData   (ResultW),
        .readData1_c (rd1_c),
        .readData2_c (rd2_c)
    );

    // Main decoder; unrecognised opcodes (including all-zero) leave bubble controls.
    always_comb begin
        ctrl   = '0;
        immSel = IMM_NONE;
        case (opcode)
            OP_RALU: begin
                ctrl.regWrite   = 1'b1;
                ctrl.aluControl = aluDecode(funct3, funct7b5, 1'b1);
            end
            OP_IALU: begin
                ctrl.regWrite   = 1'b1;
                ctrl.aluSrcB    = 1'b1;
                ctrl.aluControl = aluDecode(funct3, funct7b5, 1'b0);
                immSel          = IMM_I;
            end
            OP_LOAD: begin
                ctrl.regWrite  = 1'b1;
                ctrl.memRead   = 1'b1;
                ctrl.aluSrcB   = 1'b1;
                ctrl.resultSrc = RES_MEM;
                immSel         = IMM_I;
            end
            OP_STORE: begin
                ctrl.memWrite = 1'b1;
                ctrl.aluSrcB  = 1'b1;
                immSel        = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch     = 1'b1;
                ctrl.aluControl = ALU_SUB;
                immSel          = IMM_B;
            end
            OP_JAL: begin
                ctrl.regWrite  = 1'b1;
                ctrl.jtype     = 1'b1;
                ctrl.aluSrcA   = 1'b1;
                ctrl.aluSrcB   = 1'b1;
                ctrl.resultSrc = RES_PC4;
                immSel         = IMM_J;
            end
            OP_JALR: begin
                ctrl.regWrite  = 1'b1;
                ctrl.jtype     = 1'b1;
                ctrl.aluSrcB   = 1'b1;
                ctrl.resultSrc = RES_PC4;
                immSel         = IMM_I;
            end
            OP_LUI: begin
                ctrl.regWrite   = 1'b1;
                ctrl.aluSrcB    = 1'b1;
                ctrl.aluControl = ALU_PASSB;
                immSel          = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluSrcA  = 1'b1;
                ctrl.aluSrcB  = 1'b1;
                immSel        = IMM_U;
            end
            default: begin
                ctrl   = '0;
                immSel = IMM_NONE;
            end
        endcase
    end

    always_comb begin
        idExNext        = '0;
        idExNext.ctrl   = ctrl;
        idExNext.rd1    = rd1_c;
        idExNext.rd2    = rd2_c;
        idExNext.immExt = immExtend(InstrD, immSel);
        idExNext.pc     = PCD;
        idExNext.rs1    = InstrD[19:15];
        idExNext.rs2    = InstrD[24:20];
        idExNext.rd     = InstrD[11:7];
        idExNext.funct3 = funct3;
    end

    // ID/EX register: a flush loads an all-zero bubble and overrides a stall.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            idEx <= '0;
        end else if (!StallE) begin
            idEx <= idExNext;
        end
    end

    assign RD1E        = idEx.rd1;
    assign RD2E        = idEx.rd2;
    assign ImmExtE     = idEx.immExt;
    assign PCE         = idEx.pc;
    assign Rs1E        = idEx.rs1;
    assign Rs2E        = idEx.rs2;
    assign RdE         = idEx.rd;
    assign Funct3E     = idEx.funct3;
    assign ALUControlE = idEx.ctrl.aluControl;
    assign ALUSrcAE    = idEx.ctrl.aluSrcA;
    assign ALUSrcBE    = idEx.ctrl.aluSrcB;
    assign ResultSrcE  = idEx.ctrl.resultSrc;
    assign RegWriteE   = idEx.ctrl.regWrite;
    assign MemWriteE   = idEx.ctrl.memWrite;
    assign MemReadE    = idEx.ctrl.memRead;
    assign BranchE     = idEx.ctrl.branch;
    assign JtypeE      = idEx.ctrl.jtype;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: a decode vector table plus hand-written
// sequences for write-through, x0, flush, stall and mid-run reset.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD, PCD, ResultW;
    logic        RegWriteW, FlushE, StallE;
    logic [4:0]  RdW;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [2:0]  Funct3E;
    logic [3:0]  ALUControlE;
    logic        ALUSrcAE, ALUSrcBE;
    logic [1:0]  ResultSrcE;
    logic        RegWriteE, MemWriteE, MemReadE, BranchE, JtypeE;

    decode_cycle dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .FlushE(FlushE), .StallE(StallE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Funct3E(Funct3E),
        .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemReadE(MemReadE), .BranchE(BranchE), .JtypeE(JtypeE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, pc, rd1, rd2, imm;
        logic [31:0] ctrl;
        logic [4:0]  rd;
        logic [2:0]  f3;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Packing order: {ALUControl, SrcA, SrcB, ResultSrc, RegWrite, MemWrite, MemRead, Branch, Jtype}
    function automatic logic [31:0] expCtrl(input logic [3:0] alu, input logic srcA, input logic srcB,
                                            input logic [1:0] res, input logic regW, input logic memW,
                                            input logic memR, input logic br, input logic jt);
        return 32'({alu, srcA, srcB, res, regW, memW, memR, br, jt});
    endfunction

    function automatic logic [31:0] dutCtrl();
        return 32'({ALUControlE, ALUSrcAE, ALUSrcBE, ResultSrcE, RegWriteE, MemWriteE,
                    MemReadE, BranchE, JtypeE});
    endfunction

    function automatic vec_t mkVec(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic [31:0] rd1, input logic [31:0] rd2,
                                   input logic [31:0] imm, input logic [31:0] ctrl,
                                   input logic [4:0] rd, input logic [2:0] f3);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
        v.ctrl = ctrl; v.rd = rd; v.f3 = f3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".RD1E"}, RD1E, 32'h0);
        check({tag, ".RD2E"}, RD2E, 32'h0);
        check({tag, ".ImmExtE"}, ImmExtE, 32'h0);
        check({tag, ".PCE"}, PCE, 32'h0);
        check({tag, ".regIdx"}, 32'({Rs1E, Rs2E, RdE, Funct3E}), 32'h0);
        check({tag, ".ctrl"}, dutCtrl(), 32'h0);
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        InstrD = 32'h0; RegWriteW = 1'b1; RdW = addr; ResultW = data;
        tick();
        RegWriteW = 1'b0;
    endtask

    vec_t        vecs[16];
    logic [31:0] ctrlAdd;
    logic [31:0] addInstr, addiX20;

    initial begin
        reset = 1'b1; InstrD = '0; PCD = '0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        FlushE = 1'b0; StallE = 1'b0;
        ctrlAdd  = expCtrl(4'h0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        addInstr = 32'h002081B3;
        addiX20  = {12'h000, 5'd20, 3'b000, 5'd6, 7'b0010011};

        // Register state assumed by the table: x1=0x100, x2=7, x5=0xDEADBEEF, rest 0
        vecs[0]  = mkVec(32'h00028313, 32'h100, 32'hDEADBEEF, 0, 32'h0,
                         expCtrl(4'h0,0,1,2'b00,1,0,0,0,0), 5'd6, 3'd0);
        vecs[1]  = mkVec(32'hFE000EE3, 32'h104, 0, 0, 32'hFFFFFFFC,
                         expCtrl(4'h1,0,0,2'b00,0,0,0,1,0), 5'd29, 3'd0);
        vecs[2]  = mkVec(32'h002081B3, 32'h108, 32'h100, 32'h7, 32'h0,
                         expCtrl(4'h0,0,0,2'b00,1,0,0,0,0), 5'd3, 3'd0);
        vecs[3]  = mkVec(32'h402081B3, 32'h10C, 32'h100, 32'h7, 32'h0,
                         expCtrl(4'h1,0,0,2'b00,1,0,0,0,0), 5'd3, 3'd0);
        vecs[4]  = mkVec(32'h4020D233, 32'h110, 32'h100, 32'h7, 32'h0,
                         expCtrl(4'h7,0,0,2'b00,1,0,0,0,0), 5'd4, 3'd5);
        vecs[5]  = mkVec(32'hFF80A383, 32'h114, 32'h100, 0, 32'hFFFFFFF8,
                         expCtrl(4'h0,0,1,2'b01,1,0,1,0,0), 5'd7, 3'd2);
        vecs[6]  = mkVec(32'h0020A623, 32'h118, 32'h100, 32'h7, 32'hC,
                         expCtrl(4'h0,0,1,2'b00,0,1,0,0,0), 5'd12, 3'd2);
        vecs[7]  = mkVec(32'hABCDE437, 32'h11C, 0, 0, 32'hABCDE000,
                         expCtrl(4'hA,0,1,2'b00,1,0,0,0,0), 5'd8, 3'd6);
        vecs[8]  = mkVec(32'h00001497, 32'h80, 0, 0, 32'h1000,
                         expCtrl(4'h0,1,1,2'b00,1,0,0,0,0), 5'd9, 3'd1);
        vecs[9]  = mkVec(32'h008000EF, 32'h124, 0, 0, 32'h8,
                         expCtrl(4'h0,1,1,2'b10,1,0,0,0,1), 5'd1, 3'd0);
        vecs[10] = mkVec(32'h00008067, 32'h128, 32'h100, 0, 32'h0,
                         expCtrl(4'h0,0,1,2'b10,1,0,0,0,1), 5'd0, 3'd0);
        vecs[11] = mkVec(32'hFFF14513, 32'h12C, 32'h7, 0, 32'hFFFFFFFF,
                         expCtrl(4'h4,0,1,2'b00,1,0,0,0,0), 5'd10, 3'd4);
        vecs[12] = mkVec(32'h4030D593, 32'h130, 32'h100, 0, 32'h403,
                         expCtrl(4'h7,0,1,2'b00,1,0,0,0,0), 5'd11, 3'd5);
        vecs[13] = mkVec(32'h0020F6B3, 32'h134, 32'h100, 32'h7, 32'h0,
                         expCtrl(4'h2,0,0,2'b00,1,0,0,0,0), 5'd13, 3'd7);
        vecs[14] = mkVec(32'h00000000, 32'h44, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0);
        vecs[15] = mkVec(32'h0020807F, 32'h13C, 32'h100, 32'h7, 32'h0, 32'h0, 5'd0, 3'd0);

        // Reset held for two edges
        tick(); tick();
        checkAllZero("reset");
        reset = 1'b0;

        // Every register reads back as zero after reset
        for (int i = 1; i < 32; i++) begin
            InstrD = {7'b0, 5'(i), 5'(i), 3'b000, 5'd0, 7'b0110011};
            tick();
            check($sformatf("resetRead.x%0d.rs1", i), RD1E, 32'h0);
            check($sformatf("resetRead.x%0d.rs2", i), RD2E, 32'h0);
        end

        writeReg(5'd1, 32'h100);
        writeReg(5'd2, 32'h7);
        writeReg(5'd5, 32'hDEADBEEF);

        for (int i = 0; i < 16; i++) begin
            InstrD = vecs[i].instr;
            PCD    = vecs[i].pc;
            tick();
            check($sformatf("vec%0d.RD1E", i), RD1E, vecs[i].rd1);
            check($sformatf("vec%0d.RD2E", i), RD2E, vecs[i].rd2);
            check($sformatf("vec%0d.ImmExtE", i), ImmExtE, vecs[i].imm);
            check($sformatf("vec%0d.PCE", i), PCE, vecs[i].pc);
            check($sformatf("vec%0d.ctrl", i), dutCtrl(), vecs[i].ctrl);
            check($sformatf("vec%0d.RdE", i), 32'(RdE), 32'(vecs[i].rd));
            check($sformatf("vec%0d.Funct3E", i), 32'(Funct3E), 32'(vecs[i].f3));
        end

        // Write-through: x5 written in the same cycle it is read
        PCD = 32'h200;
        InstrD = 32'h00028313; RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h1234;
        tick();
        check("wthru.RD1E", RD1E, 32'h1234);
        check("wthru.Rs1E", 32'(Rs1E), 32'd5);
        check("wthru.RdE", 32'(RdE), 32'd6);
        RegWriteW = 1'b0;
        tick();
        check("wthru.after", RD1E, 32'h1234);

        // x0 ignores writes, including the same-cycle bypass
        InstrD = 32'h00000313; RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFF;
        tick();
        check("x0.bypass", RD1E, 32'h0);
        RegWriteW = 1'b0;
        tick();
        check("x0.after", RD1E, 32'h0);

        // Flush loads a bubble, then normal load resumes
        InstrD = addInstr; FlushE = 1'b1;
        tick();
        checkAllZero("flush");
        FlushE = 1'b0;
        tick();
        check("postFlush.RD1E", RD1E, 32'h100);
        check("postFlush.ctrl", dutCtrl(), ctrlAdd);

        // Stall holds the add while a different instruction is presented; regfile still writes
        StallE = 1'b1; InstrD = 32'hABCDE437; PCD = 32'h300;
        RegWriteW = 1'b1; RdW = 5'd20; ResultW = 32'h55;
        tick();
        RegWriteW = 1'b0;
        tick();
        check("stall.RD1E", RD1E, 32'h100);
        check("stall.RD2E", RD2E, 32'h7);
        check("stall.ImmExtE", ImmExtE, 32'h0);
        check("stall.PCE", PCE, 32'h200);
        check("stall.RdE", 32'(RdE), 32'd3);
        check("stall.ctrl", dutCtrl(), ctrlAdd);
        StallE = 1'b0; InstrD = addiX20;
        tick();
        check("stallWrite.RD1E", RD1E, 32'h55);
        check("stallWrite.PCE", PCE, 32'h300);

        // Flush outranks stall
        FlushE = 1'b1; StallE = 1'b1; InstrD = addInstr;
        tick();
        checkAllZero("flushStall");
        FlushE = 1'b0; StallE = 1'b0;

        // Reset mid-run clears the ID/EX register and the register file
        reset = 1'b1;
        tick();
        checkAllZero("midReset");
        reset = 1'b0;
        tick();
        check("midReset.x1", RD1E, 32'h0);
        check("midReset.x2", RD2E, 32'h0);
        check("midReset.ctrl", dutCtrl(), ctrlAdd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
